// File: rtl/input_conditioner_if.sv
// ---------------------------------------------------------------------------
// input_conditioner_if : CPU-side input-port bus (port select, ack, data, irq)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface input_conditioner_if;
  logic [1:0] hilo_in;
  logic       re_i;
  logic [7:0] in_p0;
  logic [7:0] in_p1;
  logic [7:0] in_p2;
  logic [7:0] in_p3;
  logic       irq_o;

  modport master (
    output hilo_in,
    output re_i,
    input  in_p0,
    input  in_p1,
    input  in_p2,
    input  in_p3,
    input  irq_o
  );

  modport slave (
    input  hilo_in,
    input  re_i,
    output in_p0,
    output in_p1,
    output in_p2,
    output in_p3,
    output irq_o
  );
endinterface

`default_nettype wire

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner : synchronize/debounce 4 keys + 10 switches, sticky presses
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module input_conditioner #(
  parameter int DB_CYCLES = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic [3:0]   buttons,
  input  wire logic [9:0]   switches,
  input_conditioner_if.slave bus
);

  localparam int            NCH     = 14;
  localparam int            CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [NCH-1:0] raw_w;
  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;
  logic [NCH-1:0] stable_q;
  logic [NCH-1:0] stable_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [3:0]     pending_q;
  logic [3:0]     pending_d;
  logic [3:0]     press_w;
  logic           any_w;

  // Keys are active-low at the pin; channels 0..3 carry 1 = pressed.
  assign raw_w = {switches, ~buttons};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // A new press outranks a same-cycle acknowledge so no event is ever lost.
  assign press_w   = stable_d[3:0] & ~stable_q[3:0];
  assign pending_d = press_w | (pending_q & {4{~bus.re_i}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= raw_w;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign any_w     = |pending_q;
  assign bus.in_p0 = {4'b0000, stable_q[3:0]};
  assign bus.in_p1 = (bus.hilo_in == 2'b10) ? 8'h00 : {3'b000, stable_q[8:4]};
  assign bus.in_p2 = (bus.hilo_in == 2'b01) ? 8'h00 : {3'b000, stable_q[13:9]};
  assign bus.in_p3 = {any_w, 3'b000, pending_q};
  assign bus.irq_o = any_w;

endmodule

`default_nettype wire
